// File: rtl/riscv_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder: opcode constants,
// the instruction format enum, the canonical NOP, and the classify and
// immediate range-check helpers used by stage 1.
package riscv_enc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_BAD} fmt_e;

  function automatic fmt_e classify(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: f = FMT_I;
      OP_STORE:                 f = FMT_S;
      OP_BRANCH:                f = FMT_B;
      OP_REG:                   f = FMT_R;
      default:                  f = FMT_BAD;
    endcase
    return f;
  endfunction

  // Returns 1 when the immediate is encodable in the given format.
  // BAD is never ok, so "error" is simply the negation of this.
  function automatic logic imm_ok(input fmt_e f, input logic signed [31:0] imm);
    logic ok;
    case (f)
      FMT_I, FMT_S: ok = (imm >= -32'sd2048) && (imm <= 32'sd2047);
      FMT_B:        ok = (imm >= -32'sd4096) && (imm <= 32'sd4094) && !imm[0];
      FMT_R:        ok = 1'b1;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Purpose: packs instruction fields into an RV32I word by format; BAD gives NOP.
// Latency: purely combinational.  Backpressure: none (no state).
// Ports: fmt, opcode/funct3/funct7, rd/rs1/rs2, imm[12:0] in; instr[31:0] out.
module instr_pack
  import riscv_enc_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] instr
);

  always_comb begin
    instr = NOP;
    case (fmt)
      FMT_I: instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      default: instr = NOP;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Purpose: 2-stage RV32I encoder (classify/range-check, then pack/register)
//   with word-address tagging and a saturating error counter.
// Latency: 2 cycles at 1 word/cycle; in_ready drops only when both stages are
//   full and the output is stalled, or during clear/reset.
// Ports: clk, rst_n, clear; in_valid/in_ready + instruction fields + in_imm;
//   out_valid/out_ready, out_instr, out_addr, out_err; err_count.
module instr_encoder
  import riscv_enc_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  // Stage 1 holds the raw fields plus the classification result. Only the
  // low 13 immediate bits are kept: once the range check passes, that is
  // all any format needs for packing.
  logic        s1_vld;
  fmt_e        s1_fmt;
  logic        s1_err;
  logic [6:0]  s1_op;
  logic [2:0]  s1_f3;
  logic [6:0]  s1_f7;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [12:0] s1_imm;

  logic        out_fire;
  logic        s2_adv;
  logic        in_fire;
  fmt_e        in_fmt;
  logic [31:0] packed_word;

  assign out_fire = out_valid & out_ready;
  assign s2_adv   = s1_vld & (~out_valid | out_ready);
  // rst_n is folded in so the input side reads as not-ready while held in reset.
  assign in_ready = rst_n & ~clear & (~s1_vld | s2_adv);
  assign in_fire  = in_valid & in_ready;
  assign in_fmt   = classify(in_opcode);

  instr_pack u_pack (
    .fmt    (s1_fmt),
    .opcode (s1_op),
    .funct3 (s1_f3),
    .funct7 (s1_f7),
    .rd     (s1_rd),
    .rs1    (s1_rs1),
    .rs2    (s1_rs2),
    .imm    (s1_imm),
    .instr  (packed_word)
  );

  // Stage 1: classify and range-check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_fmt <= FMT_BAD;
      s1_err <= 1'b0;
      s1_op  <= '0;
      s1_f3  <= '0;
      s1_f7  <= '0;
      s1_rd  <= '0;
      s1_rs1 <= '0;
      s1_rs2 <= '0;
      s1_imm <= '0;
    end else if (clear) begin
      s1_vld <= 1'b0;
    end else if (in_fire) begin
      s1_vld <= 1'b1;
      s1_fmt <= in_fmt;
      s1_err <= ~imm_ok(in_fmt, $signed(in_imm));
      s1_op  <= in_opcode;
      s1_f3  <= in_funct3;
      s1_f7  <= in_funct7;
      s1_rd  <= in_rd;
      s1_rs1 <= in_rs1;
      s1_rs2 <= in_rs2;
      s1_imm <= in_imm[12:0];
    end else if (s2_adv) begin
      s1_vld <= 1'b0;
    end
  end

  // Stage 2: pack and register outputs; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= 1'b1;
      out_instr <= s1_err ? NOP : packed_word;
      out_err   <= s1_err;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  // out_addr names the word currently on the output, so it only moves after
  // that word is taken. A handshake coinciding with clear is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr  <= BASE_ADDR;
      err_count <= '0;
    end else if (clear) begin
      out_addr  <= BASE_ADDR;
      err_count <= '0;
    end else if (out_fire) begin
      out_addr <= out_addr + ADDR_W'(4);
      if (out_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, 16, width of the output word-address counter.
REQ-002 Parameter BASE_ADDR, 0, address tagged on the first word after reset or clear.
REQ-003 Port clk  in  1  single clock, all state on rising edge.
REQ-004 Port rst_n  in  1  asynchronous active-low reset.
REQ-005 Port in_valid / in_ready  in / out  1 / 1  input handshake, transfer when both high.
REQ-006 Port in_opcode / in_funct3 / in_funct7  in  7 / 3 / 7  instruction fields.
REQ-007 Port in_rd / in_rs1 / in_rs2  in  5 each  register indices.
REQ-008 Port in_imm  in  32  signed immediate (byte offset for B-type).
REQ-009 Port clear  in  1  synchronous flush, address and error-count reset.
REQ-010 Port out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-011 Port out_instr / out_addr / out_err  out  32 / ADDR_W / 1  encoded word, its address, error flag.
REQ-012 Port err_count  out  8  saturating count of errored words delivered.

Function
REQ-013 Format by opcode SHALL be: I = 0000011, 0010011, 1100111; S = 0100011; B = 1100011; R = 0110011; any other opcode is BAD.
REQ-014 Packing SHALL follow RV32I: I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; R {f7,rs2,rs1,f3,rd,op}.
REQ-015 Range check SHALL be: I/S in [-2048, 2047]; B in [-4096, 4094] and even; R ignores in_imm.
REQ-016 A BAD opcode or a failed range check SHALL set out_err=1 and force out_instr to 32'h00000013 (NOP).
REQ-017 For every accepted non-error word, the team's immediate generator applied to out_instr SHALL return in_imm exactly.
REQ-018 The block SHALL be a 2-stage pipeline: stage 1 classifies and range-checks, stage 2 packs and registers outputs.
REQ-019 Latency SHALL be 2 cycles from input handshake to out_valid when out_ready is held high; throughput SHALL be 1 word per cycle.
REQ-020 A stage SHALL advance when the next stage is empty or is being consumed; in_ready SHALL be combinational (stage 1 empty or advancing).
REQ-021 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable; no word may be lost, duplicated or reordered.
REQ-022 out_addr SHALL start at BASE_ADDR and increment by 4 on each output handshake, wrapping modulo 2^ADDR_W.
REQ-023 err_count SHALL increment on each output handshake with out_err=1 and saturate at 255.
REQ-024 clear=1 SHALL empty both stages, set out_addr=BASE_ADDR and err_count=0 on the next edge; in_ready SHALL be 0 that cycle; a simultaneous output handshake SHALL be ignored for counting.

Reset
REQ-025 rst_n=0 SHALL immediately clear both stage valids, out_valid, out_err and err_count, set out_instr=0 and out_addr=BASE_ADDR, and force in_ready=0.
REQ-026 After rst_n rises, in_ready SHALL be 1 in the first cycle; in-flight words at reset are discarded.

Structure
REQ-027 A shared package riscv_enc_pkg SHALL hold the opcode constants, the format enum (FMT_R, FMT_I, FMT_S, FMT_B, FMT_BAD) and the NOP constant.
REQ-028 Packing SHALL be a combinational sub-module instr_pack (format, fields, imm -> 32-bit word); the pipeline, handshake and counters stay in instr_encoder.

Verification
REQ-029 addi: op 0010011, rd 1, rs1 2, f3 0, imm -1 -> out_instr 32'hFFF10093, out_err 0, out_addr 0x0000 after 2 cycles.
REQ-030 sw then beq: (0100011, rs1 6, rs2 5, f3 010, imm 8) -> 32'h00532423 at addr 0x0000; then (1100011, rs1 1, rs2 2, f3 0, imm -4) -> 32'hFE208EE3 at addr 0x0004.
REQ-031 Errors: B imm 3, I imm 2048, opcode 1111111 -> each out_err 1 with out_instr 32'h00000013; err_count reaches 3.
REQ-032 Backpressure: 4 back-to-back words with out_ready low for 3 cycles -> in_ready drops while both stages are full; all 4 words delivered in order at 0x0, 0x4, 0x8, 0xC.
REQ-033 Wrap and clear: BASE_ADDR 0xFFFC, two words -> addrs 0xFFFC then 0x0000; then clear with one word in flight -> word dropped, next word at 0xFFFC, err_count 0.
REQ-034 Reset mid-operation: rst_n low with 2 words in flight -> out_valid 0 at once; after release, first new word emerges at BASE_ADDR.
